// File: rtl/mtl_avalon_regbank_cdc_if.sv
// mtl_avalon_regbank_cdc_if: Avalon-MM bus between the NIOS master and the Qbert register bank.
// Signals:
//   Avalon_address/read/write/writedata : master -> slave
//   Avalon_readdata/waitrequest/irq     : slave -> master
interface mtl_avalon_regbank_cdc_if;
  logic [7:0]  Avalon_address;
  logic        Avalon_read;
  logic        Avalon_write;
  logic [31:0] Avalon_writedata;
  logic [31:0] Avalon_readdata;
  logic        Avalon_waitrequest;
  logic        Avalon_irq;
  modport master (
    output Avalon_address, Avalon_read, Avalon_write, Avalon_writedata,
    input  Avalon_readdata, Avalon_waitrequest, Avalon_irq
  );
  modport slave (
    input  Avalon_address, Avalon_read, Avalon_write, Avalon_writedata,
    output Avalon_readdata, Avalon_waitrequest, Avalon_irq
  );
endinterface

// File: rtl/mtl_avalon_regbank_cdc.sv
// mtl_avalon_regbank_cdc: staged Avalon-MM registers committed atomically into iCLK-domain shadows at a frame start.
// Ports:
//   Avalon_CLK_50, iRST_n : Avalon clock; async active-low reset for both domains
//   bus                   : Avalon-MM slave (address/read/write/writedata in; readdata/waitrequest/irq out)
//   iCLK, iNewFrame       : pixel clock and frame-start pulse
//   iSPI                  : asynchronous byte, synchronised for readback
//   iDone_move, iKO_qb    : pixel-domain event levels; iPosition_qb captured on iDone_move rise
//   o*                    : shadow registers in the iCLK domain
module mtl_avalon_regbank_cdc #(
  parameter int N_CUBE = 3,
  parameter int XY_W   = 21,
  parameter int XLEN_W = 11
) (
  input  logic                    Avalon_CLK_50,
  input  logic                    iRST_n,
  mtl_avalon_regbank_cdc_if.slave bus,
  input  logic                    iCLK,
  input  logic                    iNewFrame,
  input  logic [7:0]              iSPI,
  input  logic                    iDone_move,
  input  logic                    iKO_qb,
  input  logic [N_CUBE-1:0]       iPosition_qb,
  output logic                    oEnable,
  output logic [XLEN_W-1:0]       oXLENGTH,
  output logic [XY_W-1:0]         oXYDIAG_DEMI,
  output logic [XY_W-1:0]         oRANK1_XY_OFFSET,
  output logic [N_CUBE-1:0]       oColor_state,
  output logic [XY_W-1:0]         oXY0_qb,
  output logic [2:0]              oJump_qb,
  output logic [N_CUBE-1:0]       oNext_qb
);
  logic [1:0]        ctrl_q;
  logic [XLEN_W-1:0] xlen_q;
  logic [XY_W-1:0]   xydiag_q, rank1_q, xy0_q;
  logic [N_CUBE-1:0] color_q, next_q, pos_q, hold_q;
  logic [2:0]        jump_q;
  logic [7:0]        spi_s1_q, spi_s2_q;
  logic [2:0]        done_sync_q, ko_sync_q;
  logic [31:0]       rdata_d, rdata_q;
  logic              req_q, ack_s1_q, ack_s2_q, done_st_q, ko_st_q;
  logic              req_s1_q, req_s2_q, ack_q, done_lvl_q, ko_lvl_q, ev_done_q, ev_ko_q;
  logic              pending, stall, wr, w1c, done_ev, ko_ev, unused_wd;
  logic [7:0]        a;
  logic [31:0]       wd;
  assign a         = bus.Avalon_address;
  assign wd        = bus.Avalon_writedata;
  assign unused_wd = ^wd;
  // A commit is outstanding while the returned ack has not caught up with req.
  assign pending   = req_q ^ ack_s2_q;
  // STATUS (1) and the read-only SPI (2) never stall; everything else waits for the commit to land.
  assign stall     = bus.Avalon_write & pending & (a == 8'd0 || (a >= 8'd3 && a <= 8'd11));
  assign wr        = bus.Avalon_write & ~stall;
  assign w1c       = wr & (a == 8'd1);
  // Third flop of each event synchroniser turns the toggle into a one-cycle pulse.
  assign done_ev   = done_sync_q[1] ^ done_sync_q[2];
  assign ko_ev     = ko_sync_q[1] ^ ko_sync_q[2];
  assign bus.Avalon_readdata    = rdata_q;
  assign bus.Avalon_waitrequest = stall;
  assign bus.Avalon_irq         = ctrl_q[1] & (done_st_q | ko_st_q);
  always_comb begin
    rdata_d = '0;
    case (a)
      8'd0:    rdata_d = 32'(ctrl_q);
      8'd1:    rdata_d = {29'd0, ko_st_q, done_st_q, pending};
      8'd2:    rdata_d = 32'(spi_s2_q);
      8'd3:    rdata_d = 32'(xlen_q);
      8'd4:    rdata_d = 32'(xydiag_q);
      8'd5:    rdata_d = 32'(rank1_q);
      8'd6:    rdata_d = 32'(color_q);
      8'd7:    rdata_d = 32'(xy0_q);
      8'd8:    rdata_d = 32'(jump_q);
      8'd9:    rdata_d = 32'(next_q);
      8'd10:   rdata_d = 32'(pos_q);
      default: rdata_d = '0;
    endcase
  end
  always_ff @(posedge Avalon_CLK_50 or negedge iRST_n)
    if (!iRST_n) begin
      {ctrl_q, xlen_q, xydiag_q, rank1_q, color_q, xy0_q, jump_q, next_q, pos_q} <= '0;
      {spi_s1_q, spi_s2_q, done_sync_q, ko_sync_q, rdata_q} <= '0;
      {req_q, ack_s1_q, ack_s2_q, done_st_q, ko_st_q} <= '0;
    end else begin
      spi_s1_q    <= iSPI;
      spi_s2_q    <= spi_s1_q;
      ack_s1_q    <= ack_q;
      ack_s2_q    <= ack_s1_q;
      done_sync_q <= {done_sync_q[1:0], ev_done_q};
      ko_sync_q   <= {ko_sync_q[1:0], ev_ko_q};
      if (bus.Avalon_read) rdata_q <= rdata_d;
      // hold_q was written before its toggle left the pixel domain, so it is stable here.
      if (done_ev) pos_q <= hold_q;
      // A new event outranks a same-cycle W1C.
      done_st_q <= done_ev | (done_st_q & ~(w1c & wd[1]));
      ko_st_q   <= ko_ev | (ko_st_q & ~(w1c & wd[2]));
      if (wr)
        case (a)
          8'd0:    ctrl_q   <= wd[1:0];
          8'd3:    xlen_q   <= wd[XLEN_W-1:0];
          8'd4:    xydiag_q <= wd[XY_W-1:0];
          8'd5:    rank1_q  <= wd[XY_W-1:0];
          8'd6:    color_q  <= wd[N_CUBE-1:0];
          8'd7:    xy0_q    <= wd[XY_W-1:0];
          8'd8:    jump_q   <= wd[2:0];
          8'd9:    next_q   <= wd[N_CUBE-1:0];
          8'd11:   req_q    <= ~req_q;
          default: ;
        endcase
    end
  // Staged registers are frozen while req is unacknowledged, so the multi-bit
  // shadow load samples them safely across the clock boundary.
  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      {req_s1_q, req_s2_q, ack_q, done_lvl_q, ko_lvl_q, ev_done_q, ev_ko_q, hold_q} <= '0;
      {oEnable, oXLENGTH, oXYDIAG_DEMI, oRANK1_XY_OFFSET, oColor_state, oXY0_qb, oJump_qb, oNext_qb} <= '0;
    end else begin
      req_s1_q   <= req_q;
      req_s2_q   <= req_s1_q;
      done_lvl_q <= iDone_move;
      ko_lvl_q   <= iKO_qb;
      if (iDone_move & ~done_lvl_q) begin
        hold_q    <= iPosition_qb;
        ev_done_q <= ~ev_done_q;
      end
      if (iKO_qb & ~ko_lvl_q) ev_ko_q <= ~ev_ko_q;
      if (iNewFrame & (req_s2_q ^ ack_q)) begin
        oEnable          <= ctrl_q[0];
        oXLENGTH         <= xlen_q;
        oXYDIAG_DEMI     <= xydiag_q;
        oRANK1_XY_OFFSET <= rank1_q;
        oColor_state     <= color_q;
        oXY0_qb          <= xy0_q;
        oJump_qb         <= jump_q;
        oNext_qb         <= next_q;
        ack_q            <= ~ack_q;
      end
    end
endmodule

// File: tb/tb_mtl_avalon_regbank_cdc.sv
// tb_mtl_avalon_regbank_cdc: table, directed and randomized checks of the register bank against a register-map model.
module tb_mtl_avalon_regbank_cdc;
  logic clk = 1'b0, pclk = 1'b0, rst_n = 1'b0;
  logic new_frame = 1'b0, done_mv = 1'b0, ko = 1'b0;
  logic [7:0] spi = 8'd0;
  logic [2:0] pos_in = 3'd0;
  logic en_o;
  logic [10:0] xlen_o;
  logic [20:0] xyd_o, rank_o, xy0_o;
  logic [2:0] col_o, jump_o, next_o;
  mtl_avalon_regbank_cdc_if bus();
  mtl_avalon_regbank_cdc dut (
    .Avalon_CLK_50(clk), .iRST_n(rst_n), .bus(bus), .iCLK(pclk), .iNewFrame(new_frame),
    .iSPI(spi), .iDone_move(done_mv), .iKO_qb(ko), .iPosition_qb(pos_in),
    .oEnable(en_o), .oXLENGTH(xlen_o), .oXYDIAG_DEMI(xyd_o), .oRANK1_XY_OFFSET(rank_o),
    .oColor_state(col_o), .oXY0_qb(xy0_o), .oJump_qb(jump_o), .oNext_qb(next_o)
  );
  always #10 clk = ~clk;
  always #7 pclk = ~pclk;
  int vectors = 0, miscompares = 0;
  logic [31:0] st_m [0:15];
  logic [31:0] sh_m [0:15];
  logic done_m = 1'b0, ko_m = 1'b0;
  logic [7:0] spi_m = 8'd0;
  logic [2:0] pos_m = 3'd0;
  typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [31:0] rexp; } vec_t;
  vec_t tbl [12];
  logic [7:0] alist [15];
  function automatic logic [31:0] fmask(input logic [7:0] a);
    case (a)
      8'd0: return 32'h3;
      8'd3: return 32'h7FF;
      8'd4, 8'd5, 8'd7: return 32'h1F_FFFF;
      8'd6, 8'd8, 8'd9: return 32'h7;
      default: return 32'h0;
    endcase
  endfunction
  function automatic void m_write(input logic [7:0] a, input logic [31:0] d);
    if (a == 8'd1) begin
      done_m = done_m & ~d[1];
      ko_m   = ko_m & ~d[2];
    end else if (fmask(a) != 32'h0) st_m[a[3:0]] = d & fmask(a);
  endfunction
  function automatic void m_commit();
    for (int i = 0; i < 16; i++) sh_m[i] = st_m[i];
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin st_m[i] = 32'h0; sh_m[i] = 32'h0; end
    done_m = 1'b0; ko_m = 1'b0; pos_m = 3'd0;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    if (a == 8'd1) return {29'd0, ko_m, done_m, 1'b0};
    if (a == 8'd2) return 32'(spi_m);
    if (a == 8'd10) return 32'(pos_m);
    return (fmask(a) != 32'h0) ? st_m[a[3:0]] : 32'h0;
  endfunction
  function automatic logic exp_irq();
    return st_m[0][1] & (done_m | ko_m);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wait_av(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic av_write(input logic [7:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    bus.Avalon_address = a; bus.Avalon_writedata = d; bus.Avalon_write = 1'b1;
    #1;
    while (bus.Avalon_waitrequest === 1'b1 && stalls < 400) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 400) chk("waitrequest_timeout", 32'(bus.Avalon_waitrequest), 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.Avalon_write = 1'b0;
  endtask
  task automatic wr_m(input logic [7:0] a, input logic [31:0] d);
    int s;
    av_write(a, d, s);
    m_write(a, d);
  endtask
  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] e);
    bus.Avalon_address = a; bus.Avalon_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Avalon_read = 1'b0;
    chk(nm, bus.Avalon_readdata, e);
  endtask
  task automatic pulse_frame();
    @(negedge pclk); new_frame = 1'b1;
    @(negedge pclk); new_frame = 1'b0;
    @(negedge clk);
  endtask
  task automatic done_event(input logic [2:0] p);
    @(negedge pclk); pos_in = p; done_mv = 1'b1;
    repeat (3) @(negedge pclk);
    done_mv = 1'b0;
    @(negedge clk);
  endtask
  task automatic ko_event();
    @(negedge pclk); ko = 1'b1;
    repeat (3) @(negedge pclk);
    ko = 1'b0;
    @(negedge clk);
  endtask
  task automatic chk_shadow(input string tag);
    chk({tag, ".oEnable"}, 32'(en_o), 32'(sh_m[0][0]));
    chk({tag, ".oXLENGTH"}, 32'(xlen_o), sh_m[3]);
    chk({tag, ".oXYDIAG_DEMI"}, 32'(xyd_o), sh_m[4]);
    chk({tag, ".oRANK1_XY_OFFSET"}, 32'(rank_o), sh_m[5]);
    chk({tag, ".oColor_state"}, 32'(col_o), sh_m[6]);
    chk({tag, ".oXY0_qb"}, 32'(xy0_o), sh_m[7]);
    chk({tag, ".oJump_qb"}, 32'(jump_o), sh_m[8]);
    chk({tag, ".oNext_qb"}, 32'(next_o), sh_m[9]);
  endtask
  task automatic do_commit(input string tag);
    wr_m(8'd11, $urandom);
    wait_av(6);
    m_commit();
    pulse_frame();
    wait_av(4);
    rd_chk({tag, ".status"}, 8'd1, exp_rd(8'd1));
    chk_shadow(tag);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int stalls;
    logic seen;
    logic [7:0] a;
    logic [2:0] p;
    bus.Avalon_address = 8'd0; bus.Avalon_read = 1'b0; bus.Avalon_write = 1'b0; bus.Avalon_writedata = 32'd0;
    m_reset();
    tbl[0]  = '{8'd3,   32'hFFFF_FFFF, 32'h7FF};
    tbl[1]  = '{8'd4,   32'hFFFF_FFFF, 32'h1F_FFFF};
    tbl[2]  = '{8'd5,   32'h00AB_CDEF, 32'h0B_CDEF};
    tbl[3]  = '{8'd6,   32'hFFFF_FFFE, 32'h6};
    tbl[4]  = '{8'd7,   32'h0001_2345, 32'h1_2345};
    tbl[5]  = '{8'd8,   32'h0000_000E, 32'h6};
    tbl[6]  = '{8'd9,   32'h0000_0003, 32'h3};
    tbl[7]  = '{8'd0,   32'h0000_00FF, 32'h3};
    tbl[8]  = '{8'd200, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{8'd2,   32'h0000_00FF, 32'h5A};
    tbl[10] = '{8'd10,  32'h0000_00FF, 32'h0};
    tbl[11] = '{8'd12,  32'h0000_00FF, 32'h0};
    alist = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd200, 8'd255};
    // reset state
    wait_av(3);
    chk("rst.readdata", bus.Avalon_readdata, 32'h0);
    chk("rst.waitrequest", 32'(bus.Avalon_waitrequest), 32'h0);
    rst_n = 1'b1;
    wait_av(2);
    for (int i = 0; i <= 12; i++) rd_chk($sformatf("rst.rd%0d", i), 8'(i), 32'h0);
    chk("rst.irq", 32'(bus.Avalon_irq), 32'h0);
    chk_shadow("rst");
    // table: truncating writes, RO and unmapped addresses
    spi = 8'h5A; spi_m = 8'h5A;
    wait_av(4);
    for (int i = 0; i < 12; i++) begin
      wr_m(tbl[i].addr, tbl[i].wdata);
      rd_chk($sformatf("tbl%0d.a%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].rexp);
    end
    // commit waits for a frame start
    wr_m(8'd11, 32'h0);
    wait_av(20);
    chk("commit.xy0_before_frame", 32'(xy0_o), 32'h0);
    rd_chk("commit.pending_set", 8'd1, 32'h1);
    av_write(8'd1, 32'h0, stalls);
    chk("commit.w1c_no_wait", 32'(stalls), 32'h0);
    m_commit();
    pulse_frame();
    wait_av(3);
    rd_chk("commit.pending_clr", 8'd1, 32'h0);
    chk("commit.oXY0_qb", 32'(xy0_o), 32'h1_2345);
    chk_shadow("commit1");
    // a write during a pending commit stalls and misses that commit
    wr_m(8'd11, 32'h0);
    wait_av(6);
    fork
      begin av_write(8'd8, 32'h5, stalls); m_write(8'd8, 32'h5); end
      begin wait_av(15); m_commit(); pulse_frame(); end
    join
    chk("pend.jump_stalled", 32'(stalls >= 10), 32'h1);
    rd_chk("pend.jump_rd", 8'd8, 32'h5);
    chk("pend.oJump_kept", 32'(jump_o), 32'h6);
    do_commit("commit2");
    chk("commit2.oJump_qb", 32'(jump_o), 32'h5);
    // done / KO events and W1C
    done_event(3'b101);
    wait_av(6);
    pos_m = 3'd5; done_m = 1'b1;
    rd_chk("ev.position", 8'd10, 32'h5);
    rd_chk("ev.status", 8'd1, 32'h2);
    chk("ev.irq_set", 32'(bus.Avalon_irq), 32'h1);
    wr_m(8'd1, 32'h2);
    chk("ev.irq_clr", 32'(bus.Avalon_irq), 32'h0);
    rd_chk("ev.status_clr", 8'd1, 32'h0);
    // continuous W1C stream: a colliding event must still surface for a cycle
    seen = 1'b0;
    bus.Avalon_address = 8'd1; bus.Avalon_writedata = 32'h2; bus.Avalon_write = 1'b1;
    fork
      done_event(3'b010);
      for (int i = 0; i < 20; i++) begin @(negedge clk); seen = seen | bus.Avalon_irq; end
    join
    bus.Avalon_write = 1'b0;
    pos_m = 3'd2;
    chk("ev.set_beats_w1c", 32'(seen), 32'h1);
    rd_chk("ev.stream_status", 8'd1, 32'h0);
    rd_chk("ev.stream_position", 8'd10, 32'h2);
    ko_event();
    wait_av(6);
    ko_m = 1'b1;
    rd_chk("ko.status", 8'd1, 32'h4);
    chk("ko.irq", 32'(bus.Avalon_irq), 32'h1);
    wr_m(8'd1, 32'h4);
    rd_chk("ko.status_clr", 8'd1, 32'h0);
    // reset between COMMIT and frame abandons the commit
    wr_m(8'd3, 32'h123);
    wr_m(8'd11, 32'h0);
    wait_av(10);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_shadow("rstmid");
    chk("rstmid.irq", 32'(bus.Avalon_irq), 32'h0);
    chk("rstmid.readdata", bus.Avalon_readdata, 32'h0);
    wait_av(3);
    rst_n = 1'b1;
    wait_av(3);
    pulse_frame();
    wait_av(6);
    chk_shadow("rstpost");
    rd_chk("rstpost.status", 8'd1, 32'h0);
    // randomized operations against the register-map model
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          a = alist[$urandom_range(0, 14)];
          wr_m(a, $urandom);
        end
        4, 5, 6: begin
          a = alist[$urandom_range(0, 14)];
          rd_chk($sformatf("rnd%0d.rd%0d", n, a), a, exp_rd(a));
        end
        7: begin
          if ($urandom_range(0, 1) == 0) begin
            p = 3'($urandom);
            done_event(p);
            pos_m = p; done_m = 1'b1;
          end else begin
            ko_event();
            ko_m = 1'b1;
          end
          wait_av(6);
        end
        8: do_commit($sformatf("rnd%0d.commit", n));
        default: begin
          spi = 8'($urandom); spi_m = spi;
          wait_av(4);
        end
      endcase
      chk($sformatf("rnd%0d.irq", n), 32'(bus.Avalon_irq), 32'(exp_irq()));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mtl_avalon_regbank_cdc.md
# mtl_avalon_regbank_cdc

Parametrised Avalon-MM register bank for the MTL Qbert display path. The NIOS writes game and map parameters into staged registers in the Avalon_CLK_50 domain. A COMMIT transfers them atomically into shadow registers in the LCD pixel-clock domain at the next frame boundary, so the renderer never sees a half-updated map. Pixel-domain events (done_move, KO) are carried back as sticky status bits with an optional interrupt.

## Interface
- N_CUBE, 3, number of cubes; width of colour/next/position fields (1..32)
- XY_W, 21, width of packed XY fields (XYDIAG_DEMI, RANK1_XY_OFFSET, XY0_QB)
- XLEN_W, 11, width of XLENGTH
- Avalon_CLK_50  in  1  Avalon clock
- iRST_n  in  1  reset, asynchronous, active-low; resets both clock domains
- Avalon_address  in  8  word index
- Avalon_read / Avalon_write  in  1  strobes
- Avalon_writedata  in  32  write data
- Avalon_readdata  out  32  read data, registered
- Avalon_waitrequest  out  1  stall for writes during a pending commit
- Avalon_irq  out  1  level interrupt
- iCLK  in  1  pixel clock
- iNewFrame  in  1  pixel-domain frame-start pulse
- iSPI  in  8  asynchronous input
- iDone_move, iKO_qb  in  1  pixel-domain levels
- iPosition_qb  in  N_CUBE  pixel-domain Qbert position
- oEnable, oXLENGTH[XLEN_W], oXYDIAG_DEMI[XY_W], oRANK1_XY_OFFSET[XY_W], oColor_state[N_CUBE], oXY0_qb[XY_W], oJump_qb[3], oNext_qb[N_CUBE]  out  shadow registers, iCLK domain

## Operation
- Register map (word addresses):
  - 0 CTRL RW: b0 enable, b1 irq_en
  - 1 STATUS: b0 commit_pending (RO); b1 done sticky and b2 ko sticky (W1C)
  - 2 SPI RO: 2-flop-synchronised iSPI
  - 3 XLENGTH; 4 XYDIAG_DEMI; 5 RANK1_XY_OFFSET; 6 COLOR_STATE; 7 XY0_QB; 8 JUMP; 9 NEXT_QB: all RW staged
  - 10 POSITION_QB RO
  - 11 COMMIT WO: any data value
- Writes truncate to field width. Reads zero-extend. Unmapped addresses read 0; writes to them are ignored.
- CTRL, including enable, is also staged and committed.
- Commit handshake:
  - A COMMIT write sets commit_pending and toggles req.
  - req is 2-flop synchronised into iCLK.
  - On the first iNewFrame with an unserviced req, all shadows load from the staged registers in one iCLK edge, and ack toggles.
  - ack is 2-flop synchronised back; when it matches req, commit_pending clears.
- While commit_pending = 1, writes to addresses 0 and 3–11 assert Avalon_waitrequest until the pending bit clears. STATUS W1C writes never wait.
- Events:
  - A rising edge of iDone_move captures iPosition_qb into a pixel-domain hold register and toggles ev_done.
  - After ev_done synchronises, POSITION_QB loads from the hold register and STATUS.b1 sets.
  - iKO_qb rising edge → STATUS.b2 by the same toggle scheme (no data).
- Avalon_irq = irq_en_staged & (b1 | b2).
- A set and a W1C on the same cycle: set wins.

## Timing
- Reset: all staged and shadow registers, readdata, STATUS, waitrequest, irq, and synchronisers = 0.
- Read latency is 1 cycle; reads never wait.
- Staged write is visible to readback on the next cycle.
- Commit to shadow update: 2–3 iCLK cycles of synchronisation, plus the wait for the next iNewFrame.
- commit_pending clear: 2–3 Avalon cycles after the ack toggle.
- Event to STATUS set: 2–3 Avalon cycles after the iCLK edge that sees the rising edge.
- iDone_move edges spaced by 4 or more Avalon cycles are each registered. Closer edges may merge; this is acceptable.
- Asserting iRST_n mid-commit abandons the commit: shadows = 0, pending = 0, no stale ack afterwards.

## Test plan
- Reset, then read addresses 0–12 → all 0; irq = 0; all o* = 0.
- Write XLENGTH = 0xFFFF_FFFF, then read → 0x7FF. Write address 200 → ignored, reads 0.
- Write XY0_QB = 0x12345, then COMMIT with no iNewFrame → oXY0_qb stays 0 and STATUS.b0 = 1. Pulse iNewFrame → oXY0_qb = 0x12345 and STATUS.b0 = 0 within 4 Avalon cycles.
- With a commit pending, write JUMP = 5 → waitrequest held until pending clears, then JUMP reads 5. oJump_qb keeps its previous value until the next commit.
- irq_en = 1 committed; raise iDone_move with iPosition_qb = 3'b101 → POSITION_QB = 5, STATUS = 0x2, irq = 1. W1C 0x2 → irq = 0. Simultaneous new event and W1C → b1 stays 1.
- Assert iRST_n low between COMMIT and iNewFrame → all outputs 0. After release, the next iNewFrame leaves shadows at 0.
